// File: rtl/lfsr_pkg.sv
// Shared tap table, per-channel seed derivation and FSM state type
// for the lfsr_bank block (optional feature: LFSR_BANK_LOCKUP_EN).
package lfsr_pkg;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } lfsr_state_e;

    function automatic logic [31:0] lfsr_bits(
        input int a,
        input int b,
        input int c,
        input int d
    );
        logic [31:0] m;
        m = '0;
        if (a > 0) m[a-1] = 1'b1;
        if (b > 0) m[b-1] = 1'b1;
        if (c > 0) m[c-1] = 1'b1;
        if (d > 0) m[d-1] = 1'b1;
        return m;
    endfunction

    // Maximal-length XNOR taps, 1-based positions as usually tabulated
    function automatic logic [31:0] lfsr_taps(input int wid);
        case (wid)
            3:       return lfsr_bits(3, 2, 0, 0);
            4:       return lfsr_bits(4, 3, 0, 0);
            5:       return lfsr_bits(5, 3, 0, 0);
            6:       return lfsr_bits(6, 5, 0, 0);
            7:       return lfsr_bits(7, 6, 0, 0);
            8:       return lfsr_bits(8, 6, 5, 4);
            9:       return lfsr_bits(9, 5, 0, 0);
            10:      return lfsr_bits(10, 7, 0, 0);
            11:      return lfsr_bits(11, 9, 0, 0);
            12:      return lfsr_bits(12, 6, 4, 1);
            13:      return lfsr_bits(13, 4, 3, 1);
            14:      return lfsr_bits(14, 5, 3, 1);
            15:      return lfsr_bits(15, 14, 0, 0);
            16:      return lfsr_bits(16, 15, 13, 4);
            17:      return lfsr_bits(17, 14, 0, 0);
            18:      return lfsr_bits(18, 11, 0, 0);
            19:      return lfsr_bits(19, 6, 2, 1);
            20:      return lfsr_bits(20, 17, 0, 0);
            21:      return lfsr_bits(21, 19, 0, 0);
            22:      return lfsr_bits(22, 21, 0, 0);
            23:      return lfsr_bits(23, 18, 0, 0);
            24:      return lfsr_bits(24, 23, 22, 17);
            25:      return lfsr_bits(25, 22, 0, 0);
            26:      return lfsr_bits(26, 6, 2, 1);
            27:      return lfsr_bits(27, 5, 2, 1);
            28:      return lfsr_bits(28, 25, 0, 0);
            29:      return lfsr_bits(29, 27, 0, 0);
            30:      return lfsr_bits(30, 6, 4, 1);
            31:      return lfsr_bits(31, 28, 0, 0);
            32:      return lfsr_bits(32, 22, 2, 1);
            default: return lfsr_bits(3, 2, 0, 0);
        endcase
    endfunction

    function automatic logic [31:0] lfsr_ch_seed(
        input logic [31:0] seed,
        input int          k,
        input int          wid
    );
        logic [31:0] m;
        logic [31:0] r;
        int          n;
        m = (wid >= 32) ? '1 : ((32'd1 << wid) - 32'd1);
        r = seed & m;
        n = k % wid;
        // Fixed bound keeps the loop unrollable; rotation is within wid bits
        for (int i = 0; i < 32; i++) begin
            if (i < n) r = ((r << 1) | (r >> (wid - 1))) & m;
        end
        return (r ^ 32'(k)) & m;
    endfunction

endpackage

// File: rtl/lfsr_chan.sv
// One XNOR LFSR channel: state register, feedback and optional
// lockup recovery (LFSR_BANK_LOCKUP_EN).
module lfsr_chan
    import lfsr_pkg::*;
#(
    parameter int             WID     = 17,
    parameter logic [WID-1:0] RST_VAL = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld_i,
    input  logic [WID-1:0] seed_i,
    input  logic           step_i,
    input  logic           cyc_i,
    output logic [WID-1:0] state_o,
    output logic           lockup_o
);

    localparam logic [WID-1:0] TAPS = WID'(lfsr_taps(WID));

    logic [WID-1:0] s_q;
    logic [WID-1:0] s_d;
    logic           fb;

    assign fb      = ~(^(s_q & TAPS) ^ cyc_i);
    assign state_o = s_q;

`ifdef LFSR_BANK_LOCKUP_EN
    logic [WID-1:0] lock_val;
    logic           locked;
    logic           lock_q;
    logic           lock_d;

    assign lock_val = cyc_i ? '0 : '1;
    assign locked   = (s_q == lock_val);
    assign lockup_o = lock_q;

    // A stuck state is kicked to its complement instead of stepping
    always_comb begin
        s_d    = s_q;
        lock_d = lock_q;
        if (ld_i) begin
            s_d    = seed_i;
            lock_d = 1'b0;
        end else begin
            if (locked) lock_d = 1'b1;
            if (step_i) begin
                s_d = locked ? ~lock_val : {s_q[WID-2:0], fb};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= RST_VAL;
            lock_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            lock_q <= lock_d;
        end
    end
`else
    assign lockup_o = 1'b0;

    always_comb begin
        s_d = s_q;
        if (ld_i) begin
            s_d = seed_i;
        end else if (step_i) begin
            s_d = {s_q[WID-2:0], fb};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= RST_VAL;
        end else begin
            s_q <= s_d;
        end
    end
`endif

endmodule

// File: rtl/lfsr_bank.sv
// Bank of NCH LFSR channels with shared seed load, warm-up sequencer
// and valid/ready output stream (optional feature: LFSR_BANK_LOCKUP_EN).
module lfsr_bank
    import lfsr_pkg::*;
#(
    parameter int          WID      = 17,
    parameter int          NCH      = 4,
    parameter int          WARMUP   = 16,
    parameter logic [31:0] RST_SEED = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_ld,
    input  logic [WID-1:0]     seed_i,
    input  logic [NCH-1:0]     cyc,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [NCH*WID-1:0] o_data,
    output logic               busy,
    output logic [NCH-1:0]     lockup_o
);

    lfsr_state_e state_q;
    logic        step;

    assign o_valid = (state_q == RUN);
    assign busy    = (state_q == WARM);
    // A load takes priority and drops the beat presented in that cycle
    assign step    = ~seed_ld & (busy | (o_valid & o_ready));

    if (WARMUP > 0) begin : g_warm
        localparam int            CW   = $clog2(WARMUP + 1);
        localparam logic [CW-1:0] WCNT = CW'(WARMUP);

        logic [CW-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= WARM;
                cnt_q   <= WCNT;
            end else if (seed_ld) begin
                state_q <= WARM;
                cnt_q   <= WCNT;
            end else if (state_q == WARM) begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_q <= RUN;
            end
        end
    end else begin : g_nowarm
        assign state_q = RUN;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        localparam logic [WID-1:0] RV =
            WID'(lfsr_ch_seed(RST_SEED, k, WID));

        logic [WID-1:0] seed_k;

        assign seed_k = WID'(lfsr_ch_seed(32'(seed_i), k, WID));

        lfsr_chan #(
            .WID     (WID),
            .RST_VAL (RV)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .ld_i     (seed_ld),
            .seed_i   (seed_k),
            .step_i   (step),
            .cyc_i    (cyc[k]),
            .state_o  (o_data[k*WID +: WID]),
            .lockup_o (lockup_o[k])
        );
    end

endmodule
